// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU operand and response bundle for alu_arbiter
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             req_valid_0;
  logic             req_ready_0;
  logic [5:0]       req_instr_0;
  logic [WIDTH-1:0] req_rs1_0;
  logic [WIDTH-1:0] req_rs2_0;
  logic [WIDTH-1:0] req_imm_0;
  logic [4:0]       req_shamt_0;
  logic [31:0]      req_pc_0;
  logic [TAG_W-1:0] req_tag_0;

  logic             req_valid_1;
  logic             req_ready_1;
  logic [5:0]       req_instr_1;
  logic [WIDTH-1:0] req_rs1_1;
  logic [WIDTH-1:0] req_rs2_1;
  logic [WIDTH-1:0] req_imm_1;
  logic [4:0]       req_shamt_1;
  logic [31:0]      req_pc_1;
  logic [TAG_W-1:0] req_tag_1;

  logic [5:0]       alu_instr;
  logic [WIDTH-1:0] alu_rs1;
  logic [WIDTH-1:0] alu_rs2;
  logic [WIDTH-1:0] alu_imm;
  logic [4:0]       alu_shamt;
  logic [31:0]      alu_pc;
  logic [WIDTH-1:0] alu_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [WIDTH-1:0] rsp_data;

  modport slave (
    input  req_valid_0, req_instr_0, req_rs1_0, req_rs2_0, req_imm_0, req_shamt_0, req_pc_0, req_tag_0,
    input  req_valid_1, req_instr_1, req_rs1_1, req_rs2_1, req_imm_1, req_shamt_1, req_pc_1, req_tag_1,
    output req_ready_0, req_ready_1,
    output alu_instr, alu_rs1, alu_rs2, alu_imm, alu_shamt, alu_pc,
    input  alu_out,
    output rsp_valid, rsp_id, rsp_tag, rsp_data,
    input  rsp_ready
  );

  modport master (
    output req_valid_0, req_instr_0, req_rs1_0, req_rs2_0, req_imm_0, req_shamt_0, req_pc_0, req_tag_0,
    output req_valid_1, req_instr_1, req_rs1_1, req_rs2_1, req_imm_1, req_shamt_1, req_pc_1, req_tag_1,
    input  req_ready_0, req_ready_1,
    input  alu_instr, alu_rs1, alu_rs2, alu_imm, alu_shamt, alu_pc,
    output alu_out,
    input  rsp_valid, rsp_id, rsp_tag, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin ALU arbiter with credit-managed response FIFO
module alu_arbiter #(
  parameter int         WIDTH      = 32,
  parameter int         TAG_W      = 4,
  parameter int         DEPTH      = 4,
  parameter logic [5:0] IDLE_INSTR = 6'h3F
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  alu_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + TAG_W + WIDTH;

  logic             prio_q, prio_d;
  logic             if_valid_q, if_valid_d;
  logic             if_id_q, if_id_d;
  logic [TAG_W-1:0] if_tag_q, if_tag_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] occupancy;
  logic             credit;
  logic             grant_0, grant_1;
  logic             push, pop;

  // Credit counts queued plus in-flight results, so it never depends on rsp_ready.
  // Reset also withholds grants so the request side looks idle while rst is high.
  always_comb begin
    occupancy = count_q + CNT_W'(if_valid_q);
    credit    = (occupancy < CNT_W'(DEPTH)) && !flush && !rst;
    grant_0   = credit && bus.req_valid_0 && (!bus.req_valid_1 || !prio_q);
    grant_1   = credit && bus.req_valid_1 && (!bus.req_valid_0 ||  prio_q);
  end

  assign bus.req_ready_0 = grant_0;
  assign bus.req_ready_1 = grant_1;

  // Steer the granted requester's operands onto the ALU; idle code and zeros otherwise.
  always_comb begin
    bus.alu_instr = IDLE_INSTR;
    bus.alu_rs1   = '0;
    bus.alu_rs2   = '0;
    bus.alu_imm   = '0;
    bus.alu_shamt = '0;
    bus.alu_pc    = '0;
    if (grant_0) begin
      bus.alu_instr = bus.req_instr_0;
      bus.alu_rs1   = bus.req_rs1_0;
      bus.alu_rs2   = bus.req_rs2_0;
      bus.alu_imm   = bus.req_imm_0;
      bus.alu_shamt = bus.req_shamt_0;
      bus.alu_pc    = bus.req_pc_0;
    end else if (grant_1) begin
      bus.alu_instr = bus.req_instr_1;
      bus.alu_rs1   = bus.req_rs1_1;
      bus.alu_rs2   = bus.req_rs2_1;
      bus.alu_imm   = bus.req_imm_1;
      bus.alu_shamt = bus.req_shamt_1;
      bus.alu_pc    = bus.req_pc_1;
    end
  end

  // Round-robin priority flips away from the winner; in-flight stage tracks the ALU latency.
  always_comb begin
    prio_d = prio_q;
    if (grant_0) begin
      prio_d = 1'b1;
    end else if (grant_1) begin
      prio_d = 1'b0;
    end
    if_valid_d = grant_0 || grant_1;
    if_id_d    = grant_1;
    if_tag_d   = grant_1 ? bus.req_tag_1 : bus.req_tag_0;
  end

  assign push = if_valid_q;
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  assign bus.rsp_valid = (count_q != '0);
  assign {bus.rsp_id, bus.rsp_tag, bus.rsp_data} = mem_q[rd_ptr_q];

  // Response FIFO: the in-flight result lands as alu_out becomes valid; flush empties it.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {if_id_q, if_tag_q, bus.alu_out};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_id_q    <= 1'b0;
      if_tag_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      prio_q     <= prio_d;
      if_valid_q <= if_valid_d;
      if_id_q    <= if_id_d;
      if_tag_q   <= if_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  alu_arbiter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH), .IDLE_INSTR(6'h3F)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  // Stand-in ALU with registered inputs: result is valid the cycle after operands are driven.
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] imm, input logic [4:0] sh, input logic [31:0] pc);
    case (op)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a + imm;
      6'd3:    return a << sh;
      6'd4:    return pc + imm;
      default: return '0;
    endcase
  endfunction

  logic [5:0]  a_instr = 6'h3F;
  logic [31:0] a_rs1 = '0, a_rs2 = '0, a_imm = '0, a_pc = '0;
  logic [4:0]  a_shamt = '0;
  always @(posedge clk) begin
    a_instr <= bus.alu_instr;
    a_rs1   <= bus.alu_rs1;
    a_rs2   <= bus.alu_rs2;
    a_imm   <= bus.alu_imm;
    a_shamt <= bus.alu_shamt;
    a_pc    <= bus.alu_pc;
  end
  assign bus.alu_out = alu_fn(a_instr, a_rs1, a_rs2, a_imm, a_shamt, a_pc);

  // Reference: list of outstanding results in acceptance order, each visible two cycles after accept.
  typedef struct {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] data;
    int          avail;
  } exp_t;
  exp_t q[$];
  bit   m_prio;
  int   cyc;
  int   checks;
  int   errors;

  logic        s_ready0, s_ready1, s_rsp_valid, s_pop, s_rsp_id;
  logic [3:0]  s_rsp_tag;
  logic [31:0] s_rsp_data;

  task automatic set_port0(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [3:0] tag);
    bus.req_instr_0 = op; bus.req_rs1_0 = a; bus.req_rs2_0 = b; bus.req_imm_0 = imm;
    bus.req_shamt_0 = 5'd0; bus.req_pc_0 = 32'h1000; bus.req_tag_0 = tag;
  endtask

  task automatic set_port1(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [3:0] tag);
    bus.req_instr_1 = op; bus.req_rs1_1 = a; bus.req_rs2_1 = b; bus.req_imm_1 = imm;
    bus.req_shamt_1 = 5'd0; bus.req_pc_1 = 32'h2000; bus.req_tag_1 = tag;
  endtask

  task automatic rand_ports();
    set_port0(6'($urandom_range(0, 4)), $urandom, $urandom, $urandom, 4'($urandom));
    set_port1(6'($urandom_range(0, 4)), $urandom, $urandom, $urandom, 4'($urandom));
    bus.req_shamt_0 = 5'($urandom);
    bus.req_shamt_1 = 5'($urandom);
    bus.req_pc_0    = $urandom;
    bus.req_pc_1    = $urandom;
  endtask

  task automatic model_reset();
    q.delete();
    m_prio = 1'b0;
  endtask

  // One clock cycle: inputs already driven after the falling edge; compare against the reference, then advance.
  task automatic step();
    logic cr, e0, e1, ev;
    exp_t e;
    #1;
    cr = (q.size() < DEPTH) && !flush;
    e0 = cr && bus.req_valid_0 && (!bus.req_valid_1 || m_prio == 1'b0);
    e1 = cr && bus.req_valid_1 && (!bus.req_valid_0 || m_prio == 1'b1);
    ev = (q.size() > 0) && (q[0].avail <= cyc);
    s_ready0    = bus.req_ready_0;
    s_ready1    = bus.req_ready_1;
    s_rsp_valid = bus.rsp_valid;
    s_pop       = bus.rsp_valid && bus.rsp_ready;
    s_rsp_id    = bus.rsp_id;
    s_rsp_tag   = bus.rsp_tag;
    s_rsp_data  = bus.rsp_data;
    checks++;
    if ({bus.req_ready_0, bus.req_ready_1} !== {e0, e1}) begin
      errors++;
      $display("FAIL grant cyc=%0d got=%b%b exp=%b%b", cyc, bus.req_ready_0, bus.req_ready_1, e0, e1);
    end
    checks++;
    if (bus.rsp_valid !== ev) begin
      errors++;
      $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, ev);
    end
    if (ev) begin
      checks++;
      if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== {q[0].id, q[0].tag, q[0].data}) begin
        errors++;
        $display("FAIL rsp_head cyc=%0d got id=%0d tag=%0d data=%h exp id=%0d tag=%0d data=%h",
                 cyc, bus.rsp_id, bus.rsp_tag, bus.rsp_data, q[0].id, q[0].tag, q[0].data);
      end
    end
    if (!e0 && !e1) begin
      checks++;
      if ({bus.alu_instr, bus.alu_rs1, bus.alu_rs2, bus.alu_imm} !== {6'h3F, 96'd0}) begin
        errors++;
        $display("FAIL alu_idle cyc=%0d got instr=%h rs1=%h exp instr=3f rs1=0", cyc, bus.alu_instr, bus.alu_rs1);
      end
    end
    if (ev && bus.rsp_ready) void'(q.pop_front());
    if (e0 || e1) begin
      e.id    = e1;
      e.tag   = e1 ? bus.req_tag_1 : bus.req_tag_0;
      e.data  = e1 ? alu_fn(bus.req_instr_1, bus.req_rs1_1, bus.req_rs2_1, bus.req_imm_1, bus.req_shamt_1, bus.req_pc_1)
                   : alu_fn(bus.req_instr_0, bus.req_rs1_0, bus.req_rs2_0, bus.req_imm_0, bus.req_shamt_0, bus.req_pc_0);
      e.avail = cyc + 2;
      q.push_back(e);
      m_prio = e0;
    end
    if (flush) q.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    idle_inputs();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", q.size());
    end
  endtask

  task automatic test_reset();
    rand_ports();
    bus.req_valid_0 = 1'b1;
    bus.req_valid_1 = 1'b1;
    bus.rsp_ready   = 1'b1;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({bus.req_ready_0, bus.req_ready_1, bus.rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready got=%b%b%b exp=000", bus.req_ready_0, bus.req_ready_1, bus.rsp_valid);
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== 37'd0) begin
      errors++;
      $display("FAIL reset_rsp got id=%0d tag=%0d data=%h exp=0", bus.rsp_id, bus.rsp_tag, bus.rsp_data);
    end
    checks++;
    if ({bus.alu_instr, bus.alu_rs1, bus.alu_rs2, bus.alu_imm, bus.alu_shamt, bus.alu_pc} !== {6'h3F, 133'd0}) begin
      errors++;
      $display("FAIL reset_alu got instr=%h rs1=%h pc=%h exp instr=3f others 0", bus.alu_instr, bus.alu_rs1, bus.alu_pc);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_port0(6'd2, 32'd5, 32'd0, 32'd7, 4'd3);
    bus.req_valid_0 = 1'b1;
    step();
    checks++;
    if (s_ready0 !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", s_ready0); end
    bus.req_valid_0 = 1'b0;
    step();
    checks++;
    if (s_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", s_rsp_valid); end
    step();
    checks++;
    if ({s_rsp_valid, s_rsp_id, s_rsp_tag, s_rsp_data} !== {1'b1, 1'b0, 4'd3, 32'd12}) begin
      errors++;
      $display("FAIL single_rsp got v=%b id=%0d tag=%0d data=%0d exp v=1 id=0 tag=3 data=12",
               s_rsp_valid, s_rsp_id, s_rsp_tag, s_rsp_data);
    end
    drain();
  endtask

  task automatic test_contention();
    int npop;
    logic [31:0] pdata[$];
    logic pid[$];
    do_reset();
    bus.rsp_ready = 1'b1;
    set_port0(6'd0, 32'd1, 32'd1, 32'd0, 4'd1);
    set_port1(6'd1, 32'd9, 32'd4, 32'd0, 4'd2);
    for (int i = 0; i < 6; i++) begin
      bus.req_valid_0 = 1'b1;
      bus.req_valid_1 = 1'b1;
      step();
      checks++;
      if ({s_ready0, s_ready1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_grant i=%0d got=%b%b exp=%0d", i, s_ready0, s_ready1, i % 2);
      end
      if (s_pop) begin pdata.push_back(s_rsp_data); pid.push_back(s_rsp_id); end
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_pop) begin pdata.push_back(s_rsp_data); pid.push_back(s_rsp_id); end
    end
    npop = pdata.size();
    checks++;
    if (npop != 6) begin errors++; $display("FAIL contention_count got=%0d exp=6", npop); end
    for (int k = 0; k < npop && k < 6; k++) begin
      checks++;
      if ({pid[k], pdata[k]} !== {k[0], ((k % 2) == 1) ? 32'd5 : 32'd2}) begin
        errors++;
        $display("FAIL contention_rsp k=%0d got id=%0d data=%0d exp id=%0d data=%0d", k, pid[k], pdata[k], k % 2,
                 ((k % 2) == 1) ? 5 : 2);
      end
    end
  endtask

  task automatic test_backpressure();
    int nacc, npop, first_pop, reassert;
    logic [31:0] pdata[$];
    do_reset();
    bus.rsp_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      set_port1(6'd0, 32'(nacc), 32'd100, 32'd0, 4'(nacc));
      bus.req_valid_1 = 1'b1;
      step();
      if (s_ready1) nacc++;
    end
    checks++;
    if (nacc != DEPTH || s_ready1 !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got accepted=%0d ready=%b exp accepted=4 ready=0", nacc, s_ready1);
    end
    bus.rsp_ready = 1'b1;
    npop = 0; first_pop = -1; reassert = -1;
    for (int i = 0; i < 40 && npop < 6; i++) begin
      bus.req_valid_1 = (nacc < 6);
      set_port1(6'd0, 32'(nacc), 32'd100, 32'd0, 4'(nacc));
      step();
      if (s_ready1) begin
        nacc++;
        if (reassert < 0) reassert = i;
      end
      if (s_pop) begin
        pdata.push_back(s_rsp_data);
        npop++;
        if (first_pop < 0) first_pop = i;
      end
    end
    checks++;
    if (npop != 6 || nacc != 6) begin
      errors++;
      $display("FAIL bp_total got popped=%0d accepted=%0d exp 6 and 6", npop, nacc);
    end
    checks++;
    if (reassert != first_pop + 1) begin
      errors++;
      $display("FAIL bp_reassert got cycle=%0d exp=%0d", reassert, first_pop + 1);
    end
    for (int k = 0; k < pdata.size(); k++) begin
      checks++;
      if (pdata[k] !== 32'(100 + k)) begin
        errors++;
        $display("FAIL bp_order k=%0d got=%0d exp=%0d", k, pdata[k], 100 + k);
      end
    end
    drain();
  endtask

  task automatic test_full_stream();
    int nacc, npop;
    bus.rsp_ready = 1'b0;
    nacc = 0; npop = 0;
    for (int i = 0; i < 10 && nacc < DEPTH; i++) begin
      rand_ports();
      bus.req_valid_0 = 1'b1;
      step();
      if (s_ready0) nacc++;
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 80 && nacc < 20; i++) begin
      rand_ports();
      bus.req_valid_0 = 1'b1;
      step();
      if (s_ready0) nacc++;
      if (s_pop) npop++;
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_pop) npop++;
    end
    checks++;
    if (nacc != 20 || npop != 20) begin
      errors++;
      $display("FAIL full_stream got accepted=%0d popped=%0d exp 20 and 20", nacc, npop);
    end
  endtask

  task automatic test_flush();
    int nacc;
    bus.rsp_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 3; i++) begin
      rand_ports();
      bus.req_valid_0 = 1'b1;
      step();
      if (s_ready0) nacc++;
    end
    flush = 1'b1;
    step();
    checks++;
    if (nacc != 3 || s_ready0 !== 1'b0 || s_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup got accepted=%0d ready=%b valid=%b exp 3 0 1", nacc, s_ready0, s_rsp_valid);
    end
    flush = 1'b0;
    set_port0(6'd2, 32'd20, 32'd0, 32'd22, 4'd9);
    step();
    checks++;
    if ({s_rsp_valid, s_ready0} !== 2'b01) begin
      errors++;
      $display("FAIL flush_cleared got valid=%b ready=%b exp valid=0 ready=1", s_rsp_valid, s_ready0);
    end
    bus.req_valid_0 = 1'b0;
    step();
    bus.rsp_ready = 1'b1;
    step();
    checks++;
    if ({s_rsp_valid, s_rsp_id, s_rsp_tag, s_rsp_data} !== {1'b1, 1'b0, 4'd9, 32'd42}) begin
      errors++;
      $display("FAIL flush_after got v=%b id=%0d tag=%0d data=%0d exp v=1 id=0 tag=9 data=42",
               s_rsp_valid, s_rsp_id, s_rsp_tag, s_rsp_data);
    end
    drain();
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_data;
    logic [3:0]  exp_tag;
    for (int i = 0; i < 12; i++) begin
      rand_ports();
      bus.req_valid_0 = 1'($urandom);
      bus.req_valid_1 = 1'($urandom);
      bus.rsp_ready   = 1'($urandom);
      step();
    end
    bus.req_valid_0 = 1'b1;
    bus.req_valid_1 = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready_0, bus.req_ready_1, bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== 40'd0) begin
      errors++;
      $display("FAIL async_rst_rsp got rdy=%b%b v=%b id=%0d tag=%0d data=%h exp all 0", bus.req_ready_0,
               bus.req_ready_1, bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_data);
    end
    checks++;
    if ({bus.alu_instr, bus.alu_rs1} !== {6'h3F, 32'd0}) begin
      errors++;
      $display("FAIL async_rst_alu got instr=%h rs1=%h exp instr=3f rs1=0", bus.alu_instr, bus.alu_rs1);
    end
    #1;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    rand_ports();
    exp_data = alu_fn(bus.req_instr_0, bus.req_rs1_0, bus.req_rs2_0, bus.req_imm_0, bus.req_shamt_0, bus.req_pc_0);
    exp_tag  = bus.req_tag_0;
    bus.req_valid_0 = 1'b1;
    bus.req_valid_1 = 1'b1;
    bus.rsp_ready   = 1'b1;
    step();
    checks++;
    if ({s_ready0, s_ready1} !== 2'b10) begin
      errors++;
      $display("FAIL async_rst_prio got=%b%b exp=10", s_ready0, s_ready1);
    end
    idle_inputs();
    step();
    step();
    checks++;
    if ({s_pop, s_rsp_id, s_rsp_tag, s_rsp_data} !== {1'b1, 1'b0, exp_tag, exp_data}) begin
      errors++;
      $display("FAIL async_rst_first got pop=%b id=%0d tag=%0d data=%h exp pop=1 id=0 tag=%0d data=%h",
               s_pop, s_rsp_id, s_rsp_tag, s_rsp_data, exp_tag, exp_data);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_ports();
      bus.req_valid_0 = ($urandom_range(0, 2) != 0);
      bus.req_valid_1 = ($urandom_range(0, 2) != 0);
      bus.rsp_ready   = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 39) == 0);
      step();
    end
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    idle_inputs();
    rand_ports();
    bus.rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_full_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
